// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer and stall counter.
// Latency: one cycle from an accepted input to out_valid.
// Backpressure: in_ready is registered and drops only when both entries are occupied.
module pipe_stage_skid #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        level,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   logic push;
   logic pop;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   // The main entry always drives the outputs; control is masked so an
   // empty or killed slot can never raise a write enable downstream.
   assign out_data = main_data;
   assign out_ctrl = out_valid ? main_ctrl : '0;

   // Occupancy FSM; in_ready, out_valid and level are registered with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         level     <= 2'd0;
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else if (flush) begin
         // Kill everything held; a same-cycle push is dropped, data regs keep old values.
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         level     <= 2'd0;
         main_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state     <= FULL;
                  out_valid <= 1'b1;
                  level     <= 2'd1;
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
               end
            end
            FULL: begin
               if (push && pop) begin
                  // Back-to-back transfer: replace the departing entry.
                  main_data <= in_data;
                  main_ctrl <= in_ctrl;
               end else if (push) begin
                  // Downstream stalled: park the new entry behind the main one.
                  state     <= SKID;
                  in_ready  <= 1'b0;
                  level     <= 2'd2;
                  skid_data <= in_data;
                  skid_ctrl <= in_ctrl;
               end else if (pop) begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
                  level     <= 2'd0;
                  main_ctrl <= '0;
               end
            end
            SKID: begin
               // in_ready is low here, so only a pop can move the state.
               if (pop) begin
                  state     <= FULL;
                  in_ready  <= 1'b1;
                  level     <= 2'd1;
                  main_data <= skid_data;
                  main_ctrl <= skid_ctrl;
                  skid_ctrl <= '0;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               level     <= 2'd0;
               main_ctrl <= '0;
               skid_ctrl <= '0;
            end
         endcase
      end
   end

   // Saturating count of cycles where a valid output is held off by downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios followed by random traffic.
// A queue-based reference model predicts occupancy, head entry and stall count.
// Inputs change 1ns after the rising edge; the model samples on the falling edge.
module tb_pipe_stage_skid;

   localparam int DATA_W = 96;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;
   localparam int SAT    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        level;
   logic [CNT_W-1:0]  stall_cnt;

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .level     (level),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the stage is a FIFO of at most two {ctrl,data} entries.
   logic [CTRL_W+DATA_W-1:0] q[$];
   logic [CTRL_W+DATA_W-1:0] head;
   int  stall_m   = 0;
   bit  known     = 0;
   bit  zero_data = 0;
   int  sz;
   bit  pu;
   bit  po;

   // Compare the DUT against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      if (known) begin
         sz = q.size();
         chk("level", {126'd0, level}, sz);
         chk("in_ready", {127'd0, in_ready}, (sz < 2) ? 1 : 0);
         chk("out_valid", {127'd0, out_valid}, (sz > 0) ? 1 : 0);
         chk("stall_cnt", {124'd0, stall_cnt}, stall_m);
         if (sz > 0) begin
            head = q[0];
            chk("out_data", {32'd0, out_data}, {32'd0, head[DATA_W-1:0]});
            chk("out_ctrl", {112'd0, out_ctrl}, {112'd0, head[CTRL_W+DATA_W-1:DATA_W]});
         end else begin
            chk("out_ctrl_idle", {112'd0, out_ctrl}, 128'd0);
            if (zero_data) chk("out_data_rst", {32'd0, out_data}, 128'd0);
         end
      end
      if (rst) begin
         q.delete();
         stall_m   = 0;
         zero_data = 1;
         known     = 1;
      end else if (known) begin
         sz = q.size();
         pu = in_valid && (sz < 2);
         po = (sz > 0) && out_ready;
         if (sz > 0 && !out_ready && stall_m < SAT) stall_m++;
         if (po) void'(q.pop_front());
         if (flush) q.delete();
         else if (pu) begin
            q.push_back({in_ctrl, in_data});
            zero_data = 0;
         end
      end
   end

   task automatic drive(input bit r, input bit f, input bit iv,
                        input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input bit ordy);
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   logic [DATA_W-1:0] rd;

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
      // Reset, then idle with reset values visible.
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 0);

      // Streaming at full rate.
      for (int i = 1; i <= 4; i++) drive(0, 0, 1, i, 16'h0100 + i[15:0], 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Back-pressure: two pushes stall into the skid entry, then drain in order.
      drive(0, 0, 1, 96'hA, 16'h000A, 0);
      drive(0, 0, 1, 96'hB, 16'h000B, 0);
      drive(0, 0, 1, 96'hE, 16'h000E, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Flush while in SKID with a competing push of 0xC.
      drive(0, 0, 1, 96'h1, 16'h0001, 0);
      drive(0, 0, 1, 96'h3, 16'h0003, 0);
      drive(0, 1, 1, 96'hC, 16'h00CC, 0);
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 1, 96'h5, 16'h0005, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Stall-counter saturation, cleared only by reset.
      drive(0, 0, 1, 96'h77, 16'h0007, 0);
      for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1);

      // Reset in SKID alongside push and pop, then a normal push.
      drive(0, 0, 1, 96'h21, 16'h0021, 0);
      drive(0, 0, 1, 96'h22, 16'h0022, 0);
      drive(1, 0, 1, 96'h23, 16'h0023, 1);
      drive(0, 0, 1, 96'h24, 16'h0024, 1);
      drive(0, 0, 0, 0, 0, 1);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 3000; i++) begin
         rd = {$urandom, $urandom, $urandom};
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 23) == 0),
               ($urandom_range(0, 99) < 65), rd, $urandom_range(0, 65535),
               ($urandom_range(0, 99) < 55));
      end
      drive(0, 0, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
